ga_sync_irq_gen: RTL and testbench
==================================

// Module: ga_sync_irq_gen
// PURPOSE
//  Parametrised sync/interrupt generator for the gate-array family; successor to the fixed 52-line CPC logic.
//  Re-times CRTC HSYNC/VSYNC into monitor sync (delayed, width-limited).
//  Runs the divide-by-N raster interrupt counter with VSYNC resync and Z80 acknowledge.
//  Optionally adds a Plus-style programmable raster interrupt (PRI) line compare.
// PARAMETERS
//  CNT_W      6    width of interrupt line counter irq_cnt
//  IRQ_DIV    52   lines per periodic interrupt (2..2**CNT_W)
//  IRQ_HALF   32   ack/resync threshold bit value (power of two, < IRQ_DIV)
//  HS_DELAY   2    cclk ticks from hsync_i rise to hsync_o rise
//  HS_WIDTH   4    max hsync_o width in cclk ticks
//  VS_LINES   26   max vsync_o width in lines
//  VS_RESYNC  2    hsync_i falls after vsync_i rise before counter resync
//  LINE_W     9    width of frame line counter line_cnt
// PORTS
//  clk_16    in   1       16 MHz system clock
//  reset     in   1       synchronous, active-high
//  cclk_en   in   1       1 MHz tick; all sampling/counting only when high
//  hsync_i   in   1       CRTC HSYNC
//  vsync_i   in   1       CRTC VSYNC
//  irq_ack   in   1       one-tick pulse, Z80 interrupt acknowledge
//  irq_clr   in   1       one-tick pulse, ctrl write with D[4]=1
//  pri_line  in   LINE_W  PRI compare line; 0 = PRI off
//  hsync_o   out  1       monitor HSYNC
//  vsync_o   out  1       monitor VSYNC
//  int_n     out  1       interrupt request, active low
//  irq_cnt   out  CNT_W   interrupt line counter
//  line_cnt  out  LINE_W  lines since last vsync_i rise
// BEHAVIOUR
//  Reset: hsync_o=0, vsync_o=0, int_n=1, irq_cnt=0, line_cnt=0, internal counters 0.
//  Reset is synchronous and overrides all other events.
//  Sampling: hsync_i/vsync_i registered on cclk_en; edges = registered vs previous; all state updates gated by cclk_en.
//  HSYNC: hs_cnt clears on hsync_i rise, increments while high, saturates.
//   hsync_o=1 iff hsync_i high and HS_DELAY <= hs_cnt < HS_DELAY+HS_WIDTH.
//   hsync_i shorter than HS_DELAY -> no hsync_o pulse.
//  Line event (LE) = hsync_i falling edge.
//  VSYNC FSM:
//   VS_IDLE -> VS_ACT on vsync_i rise; vsync_o=1 and vs_cnt=0 in the same cycle.
//   VS_ACT: vs_cnt++ per LE; -> VS_IDLE when vs_cnt reaches VS_LINES or vsync_i falls (first wins).
//   vsync_i rise while in VS_ACT restarts vs_cnt.
//  Periodic IRQ, per LE:
//   irq_cnt == IRQ_DIV-1 -> irq_cnt=0 and set request (int_n=0).
//   Otherwise irq_cnt++.
//  Resync: rs_cnt=0 on vsync_i rise; on the VS_RESYNC-th LE after it, irq_cnt=0.
//   At that point request is set iff irq_cnt >= IRQ_HALF; this replaces the normal LE update.
//  Ack: irq_ack -> int_n=1 and clear IRQ_HALF bit of irq_cnt (irq_cnt & ~IRQ_HALF).
//  irq_clr -> int_n=1, irq_cnt=0.
//  Same-tick precedence: reset > irq_clr > request set > irq_ack.
//   Set+ack in the same tick: int_n=0, bit still cleared.
//  line_cnt: 0 on vsync_i rise, ++ per LE, wraps at 2**LINE_W.
//  Counter update latency: one clk_16 cycle after the cclk_en tick that sampled the edge.
// CONFIGURATION
//  GA_PRI_EN defined:
//   pri_line != 0 and line_cnt+1 == pri_line at an LE -> request set.
//   Periodic IRQ sets and resync sets are suppressed while pri_line != 0; irq_cnt keeps counting.
//   pri_line change takes effect at the next LE.
//  GA_PRI_EN undefined: pri_line ignored (port kept); only periodic/resync IRQ; line_cnt still counts.
// TESTING
//  Fixed cadence: 64-tick lines (hsync_i high 14 ticks); vsync_i=8 lines every 312 lines.
//  1 Reset then normal cadence -> first periodic IRQ at 52nd LE, irq_cnt=0; later IRQs every 52 LE.
//  2 hsync_i high 14 ticks -> hsync_o high ticks 2..5 after rise (4 ticks).
//    hsync_i high 3 ticks -> hsync_o 1 tick.
//  3 vsync_i rise at irq_cnt=40 -> 2nd LE: int_n=0, irq_cnt=0.
//    Same at irq_cnt=20 -> irq_cnt=0, int_n stays 1.
//  4 int_n=0 at irq_cnt=0, irq_ack -> int_n=1, irq_cnt=0.
//    Ack at irq_cnt=45 with pending -> irq_cnt=13.
//    irq_clr same tick as set -> int_n=1, irq_cnt=0.
//  5 vsync_i high 30 lines -> vsync_o high exactly 26 LE.
//    vsync_i high 8 lines -> vsync_o falls with vsync_i.
//  6 GA_PRI_EN, pri_line=100 -> int_n=0 only at LE where line_cnt becomes 100; no 52-line IRQs; pri_line=0 restores them.

Source files
------------

// File: rtl/ga_sync_irq_gen.sv
// ga_sync_irq_gen: CRTC HSYNC/VSYNC re-timing and raster interrupt generation for the gate array.
// Define GA_PRI_EN to add the programmable raster interrupt (pri_line) compare.
module ga_sync_irq_gen #(
  parameter int CNT_W     = 6,
  parameter int IRQ_DIV   = 52,
  parameter int IRQ_HALF  = 32,
  parameter int HS_DELAY  = 2,
  parameter int HS_WIDTH  = 4,
  parameter int VS_LINES  = 26,
  parameter int VS_RESYNC = 2,
  parameter int LINE_W    = 9
) (
  input  logic              clk_16,
  input  logic              reset,
  input  logic              cclk_en,
  input  logic              hsync_i,
  input  logic              vsync_i,
  input  logic              irq_ack,
  input  logic              irq_clr,
  input  logic [LINE_W-1:0] pri_line,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              int_n,
  output logic [CNT_W-1:0]  irq_cnt,
  output logic [LINE_W-1:0] line_cnt
);

  localparam int HS_MAX = HS_DELAY + HS_WIDTH;
  localparam int HS_CW  = $clog2(HS_MAX + 1);
  localparam int VS_CW  = $clog2(VS_LINES + 1);
  localparam int RS_CW  = (VS_RESYNC > 1) ? $clog2(VS_RESYNC) : 1;

  localparam logic [HS_CW-1:0] HS_DLY_C   = HS_CW'(HS_DELAY);
  localparam logic [HS_CW-1:0] HS_MAX_C   = HS_CW'(HS_MAX);
  localparam logic [VS_CW-1:0] VS_LAST_C  = VS_CW'(VS_LINES - 1);
  localparam logic [RS_CW-1:0] RS_LAST_C  = RS_CW'(VS_RESYNC - 1);
  localparam logic [CNT_W-1:0] IRQ_LAST_C = CNT_W'(IRQ_DIV - 1);
  localparam logic [CNT_W-1:0] IRQ_HALF_C = CNT_W'(IRQ_HALF);

  typedef enum logic [0:0] {VS_IDLE = 1'b0, VS_ACT = 1'b1} vs_state_t;

  logic              hs_smp_r, vs_smp_r;
  logic              hs_rise_s, le_s, vs_rise_s, vs_fall_s;
  logic [HS_CW-1:0]  hs_cnt_r, hs_cnt_nxt_s;
  logic              hsync_r, hsync_nxt_s;
  vs_state_t         vs_state_r, vs_state_nxt_s;
  logic [VS_CW-1:0]  vs_cnt_r;
  logic              vs_cnt_clr_s, vs_cnt_inc_s, vsync_s;
  logic              rs_act_r, rs_act_nxt_s, resync_s;
  logic [RS_CW-1:0]  rs_cnt_r, rs_cnt_nxt_s;
  logic [LINE_W-1:0] line_cnt_r, line_nxt_s;
  logic [CNT_W-1:0]  irq_cnt_r, irq_nxt_s;
  logic              int_n_r, int_n_nxt_s, irq_set_s;
  logic              pri_on_s, pri_hit_s;

  // Edges compare the live input against the previous tick's sample
  always_ff @(posedge clk_16) begin
    if (reset) begin
      hs_smp_r <= 1'b0;
      vs_smp_r <= 1'b0;
    end else if (cclk_en) begin
      hs_smp_r <= hsync_i;
      vs_smp_r <= vsync_i;
    end
  end

  assign hs_rise_s = cclk_en & hsync_i & ~hs_smp_r;
  assign le_s      = cclk_en & ~hsync_i & hs_smp_r;
  assign vs_rise_s = cclk_en & vsync_i & ~vs_smp_r;
  assign vs_fall_s = cclk_en & ~vsync_i & vs_smp_r;

  // HSYNC width counter and delayed, width-limited monitor pulse
  always_comb begin
    if (hs_rise_s) begin
      hs_cnt_nxt_s = {HS_CW{1'b0}};
    end else if (hsync_i && (hs_cnt_r != HS_MAX_C)) begin
      hs_cnt_nxt_s = hs_cnt_r + HS_CW'(1);
    end else begin
      hs_cnt_nxt_s = hs_cnt_r;
    end
    hsync_nxt_s = hsync_i && (hs_cnt_nxt_s >= HS_DLY_C) && (hs_cnt_nxt_s < HS_MAX_C);
  end

  // VSYNC FSM state and line counter
  always_ff @(posedge clk_16) begin
    if (reset) begin
      vs_state_r <= VS_IDLE;
      vs_cnt_r   <= {VS_CW{1'b0}};
    end else if (cclk_en) begin
      vs_state_r <= vs_state_nxt_s;
      if (vs_cnt_clr_s) begin
        vs_cnt_r <= {VS_CW{1'b0}};
      end else if (vs_cnt_inc_s) begin
        vs_cnt_r <= vs_cnt_r + VS_CW'(1);
      end
    end
  end

  // VSYNC FSM next state; line limit and vsync_i fall both end the pulse
  always_comb begin
    vs_state_nxt_s = vs_state_r;
    case (vs_state_r)
      VS_IDLE: begin
        if (vs_rise_s) vs_state_nxt_s = VS_ACT;
        else           vs_state_nxt_s = VS_IDLE;
      end
      VS_ACT: begin
        if (vs_rise_s)                             vs_state_nxt_s = VS_ACT;
        else if (vs_fall_s)                        vs_state_nxt_s = VS_IDLE;
        else if (le_s && (vs_cnt_r == VS_LAST_C))  vs_state_nxt_s = VS_IDLE;
        else                                       vs_state_nxt_s = VS_ACT;
      end
      default: vs_state_nxt_s = VS_IDLE;
    endcase
  end

  // VSYNC FSM outputs
  always_comb begin
    vs_cnt_clr_s = vs_rise_s;
    vs_cnt_inc_s = (vs_state_r == VS_ACT) && le_s;
    vsync_s      = (vs_state_r == VS_ACT);
  end

  // Resync tracker and frame line counter
  always_comb begin
    rs_act_nxt_s = rs_act_r;
    rs_cnt_nxt_s = rs_cnt_r;
    resync_s     = 1'b0;
    if (vs_rise_s) begin
      rs_act_nxt_s = 1'b1;
      rs_cnt_nxt_s = {RS_CW{1'b0}};
    end else if (le_s && rs_act_r) begin
      if (rs_cnt_r == RS_LAST_C) begin
        resync_s     = 1'b1;
        rs_act_nxt_s = 1'b0;
      end else begin
        rs_cnt_nxt_s = rs_cnt_r + RS_CW'(1);
      end
    end else begin
      rs_cnt_nxt_s = rs_cnt_r;
    end
    if (vs_rise_s)  line_nxt_s = {LINE_W{1'b0}};
    else if (le_s)  line_nxt_s = line_cnt_r + LINE_W'(1);
    else            line_nxt_s = line_cnt_r;
  end

`ifdef GA_PRI_EN
  assign pri_on_s  = (pri_line != {LINE_W{1'b0}});
  assign pri_hit_s = pri_on_s & le_s & ((line_cnt_r + LINE_W'(1)) == pri_line);
`else
  logic unused_pri_s;
  assign pri_on_s     = 1'b0;
  assign pri_hit_s    = 1'b0;
  assign unused_pri_s = ^pri_line;
`endif

  // Interrupt counter and request; clr beats set, set beats ack on int_n
  always_comb begin
    irq_nxt_s = irq_cnt_r;
    irq_set_s = 1'b0;
    if (le_s) begin
      if (resync_s) begin
        irq_nxt_s = {CNT_W{1'b0}};
        irq_set_s = (irq_cnt_r >= IRQ_HALF_C) && !pri_on_s;
      end else if (irq_cnt_r == IRQ_LAST_C) begin
        irq_nxt_s = {CNT_W{1'b0}};
        irq_set_s = !pri_on_s;
      end else begin
        irq_nxt_s = irq_cnt_r + CNT_W'(1);
      end
    end else begin
      irq_nxt_s = irq_cnt_r;
    end
    irq_set_s = irq_set_s | pri_hit_s;
    if (irq_clr) begin
      irq_nxt_s   = {CNT_W{1'b0}};
      int_n_nxt_s = 1'b1;
    end else if (irq_set_s) begin
      int_n_nxt_s = 1'b0;
      if (irq_ack) irq_nxt_s = irq_nxt_s & ~IRQ_HALF_C;
      else         irq_nxt_s = irq_nxt_s;
    end else if (irq_ack) begin
      int_n_nxt_s = 1'b1;
      irq_nxt_s   = irq_nxt_s & ~IRQ_HALF_C;
    end else begin
      int_n_nxt_s = int_n_r;
    end
  end

  // Tick-gated state registers
  always_ff @(posedge clk_16) begin
    if (reset) begin
      hs_cnt_r   <= {HS_CW{1'b0}};
      hsync_r    <= 1'b0;
      rs_act_r   <= 1'b0;
      rs_cnt_r   <= {RS_CW{1'b0}};
      line_cnt_r <= {LINE_W{1'b0}};
      irq_cnt_r  <= {CNT_W{1'b0}};
      int_n_r    <= 1'b1;
    end else if (cclk_en) begin
      hs_cnt_r   <= hs_cnt_nxt_s;
      hsync_r    <= hsync_nxt_s;
      rs_act_r   <= rs_act_nxt_s;
      rs_cnt_r   <= rs_cnt_nxt_s;
      line_cnt_r <= line_nxt_s;
      irq_cnt_r  <= irq_nxt_s;
      int_n_r    <= int_n_nxt_s;
    end
  end

  assign hsync_o  = hsync_r;
  assign vsync_o  = vsync_s;
  assign int_n    = int_n_r;
  assign irq_cnt  = irq_cnt_r;
  assign line_cnt = line_cnt_r;

endmodule

// File: tb/tb_ga_sync_irq_gen.sv
// Directed bench for ga_sync_irq_gen: expectations queued before each line, checked after it.
// The pri_line section runs only when GA_PRI_EN is defined.
module tb_ga_sync_irq_gen;

  logic       clk_16 = 1'b0;
  logic       reset, cclk_en, hsync_i, vsync_i, irq_ack, irq_clr;
  logic [8:0] pri_line;
  logic       hsync_o, vsync_o, int_n;
  logic [5:0] irq_cnt;
  logic [8:0] line_cnt;

  ga_sync_irq_gen dut (
    .clk_16(clk_16), .reset(reset), .cclk_en(cclk_en), .hsync_i(hsync_i),
    .vsync_i(vsync_i), .irq_ack(irq_ack), .irq_clr(irq_clr), .pri_line(pri_line),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .int_n(int_n), .irq_cnt(irq_cnt),
    .line_cnt(line_cnt)
  );

  always #5 clk_16 = ~clk_16;

  localparam int S_IRQ = 0, S_INTN = 1, S_LINE = 2, S_HSHI = 3, S_HSFIRST = 4, S_VSO = 5;
  localparam int S_INTN_MID = 6, S_IRQ_MID = 7, S_VS_T0 = 8, S_VS_FALL = 9, S_HSO = 10;

  typedef struct {
    string tag;
    int    sel;
    int    exp;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   ln = 0;
  int   hs_hi, hs_first, intn_mid, irq_mid, vs_t0, vs_fall_l;
  logic prev_vso;

  function automatic int observe(input int sel);
    case (sel)
      S_IRQ:      return int'(irq_cnt);
      S_INTN:     return int'(int_n);
      S_LINE:     return int'(line_cnt);
      S_HSHI:     return hs_hi;
      S_HSFIRST:  return hs_first;
      S_VSO:      return int'(vsync_o);
      S_INTN_MID: return intn_mid;
      S_IRQ_MID:  return irq_mid;
      S_VS_T0:    return vs_t0;
      S_VS_FALL:  return vs_fall_l;
      S_HSO:      return int'(hsync_o);
      default:    return -999;
    endcase
  endfunction

  task automatic push_raw(input string tag, input int sel, input int val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = val;
    exp_q.push_back(e);
  endtask

  task automatic ex(input string nm, input int sel, input int val);
    push_raw($sformatf("%s_line%0d", nm, ln + 1), sel, val);
  endtask

  task automatic check_q();
    exp_t e;
    int   obs;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = observe(e.sel);
      total++;
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    cclk_en = 1'b1;
    @(negedge clk_16);
    cclk_en = 1'b0;
    irq_ack = 1'b0;
    irq_clr = 1'b0;
    @(negedge clk_16);
  endtask

  // One 64-tick raster line; the LE lands on tick `hi`
  task automatic run_line(input logic vs, input int hi, input int ack_t, input int clr_t);
    vsync_i  = vs;
    hs_hi    = 0;
    hs_first = -1;
    for (int t = 0; t < 64; t++) begin
      hsync_i = (t < hi);
      irq_ack = (t == ack_t);
      irq_clr = (t == clr_t);
      tick();
      if (hsync_o) begin
        hs_hi++;
        if (hs_first < 0) hs_first = t;
      end
      if (t == 0) vs_t0 = int'(vsync_o);
      if (t == 20) begin
        intn_mid = int'(int_n);
        irq_mid  = int'(irq_cnt);
      end
      if (prev_vso && !vsync_o) vs_fall_l = int'(line_cnt);
      prev_vso = vsync_o;
    end
    ln++;
    check_q();
  endtask

  task automatic run_to(input int last, input logic vs);
    while (ln < last) run_line(vs, 14, -1, -1);
  endtask

  initial begin
    reset = 1'b1; cclk_en = 1'b0; hsync_i = 1'b1; vsync_i = 1'b1;
    irq_ack = 1'b1; irq_clr = 1'b0; prev_vso = 1'b0; vs_fall_l = -1;
`ifdef GA_PRI_EN
    pri_line = 9'd0;
`else
    pri_line = 9'd7;
`endif
    @(negedge clk_16);
    tick();
    tick();
    push_raw("rst_irq_cnt", S_IRQ, 0);
    push_raw("rst_int_n", S_INTN, 1);
    push_raw("rst_line_cnt", S_LINE, 0);
    push_raw("rst_vsync_o", S_VSO, 0);
    push_raw("rst_hsync_o", S_HSO, 0);
    check_q();
    hsync_i = 1'b0; vsync_i = 1'b0; reset = 1'b0;
    @(negedge clk_16);

    ex("hs14_width", S_HSHI, 4); ex("hs14_first", S_HSFIRST, 2);
    ex("irq", S_IRQ, 1); ex("line", S_LINE, 1);
    run_line(1'b0, 14, -1, -1);
    ex("hs3_width", S_HSHI, 1); ex("hs3_first", S_HSFIRST, 2); ex("irq", S_IRQ, 2);
    run_line(1'b0, 3, -1, -1);
    ex("hs2_width", S_HSHI, 0); ex("irq", S_IRQ, 3);
    run_line(1'b0, 2, -1, -1);
    run_to(6, 1'b0);
    ex("pri_ignored_int_n", S_INTN, 1); ex("irq", S_IRQ, 7);
    run_line(1'b0, 14, -1, -1);

    run_to(50, 1'b0);
    ex("pre_irq", S_IRQ, 51); ex("pre_int_n", S_INTN, 1);
    run_line(1'b0, 14, -1, -1);
    ex("irq1_int_n", S_INTN_MID, 0); ex("irq1_cnt", S_IRQ_MID, 0);
    ex("ack0_int_n", S_INTN, 1); ex("ack0_cnt", S_IRQ, 0); ex("line", S_LINE, 52);
    run_line(1'b0, 14, 30, -1);

    run_to(103, 1'b0);
    ex("irq2_int_n", S_INTN, 0); ex("irq2_cnt", S_IRQ, 0);
    run_line(1'b0, 14, -1, -1);
    run_to(148, 1'b0);
    ex("pend45_int_n", S_INTN_MID, 0); ex("pend45_cnt", S_IRQ_MID, 45);
    ex("ack45_cnt", S_IRQ, 13); ex("ack45_int_n", S_INTN, 1);
    run_line(1'b0, 14, 30, -1);

    run_to(186, 1'b0);
    ex("pre_clr_cnt", S_IRQ, 51);
    run_line(1'b0, 14, -1, -1);
    ex("clr_set_mid", S_INTN_MID, 1); ex("clr_set_int_n", S_INTN, 1); ex("clr_set_cnt", S_IRQ, 0);
    run_line(1'b0, 14, -1, 14);

    run_to(239, 1'b0);
    ex("set_ack_int_n", S_INTN, 0); ex("set_ack_cnt", S_IRQ, 0);
    run_line(1'b0, 14, 14, -1);
    ex("ack_int_n", S_INTN, 1); ex("ack_cnt", S_IRQ, 1);
    run_line(1'b0, 14, 30, -1);

    run_to(279, 1'b0);
    ex("pre_rs40_cnt", S_IRQ, 40);
    run_line(1'b0, 14, -1, -1);
    vs_fall_l = -1;
    ex("rs40_le1_cnt", S_IRQ, 41); ex("rs40_le1_int_n", S_INTN, 1);
    ex("vs_rise_line", S_LINE, 1); ex("vs_rise_vso", S_VS_T0, 1);
    run_line(1'b1, 14, -1, -1);
    ex("rs40_int_n", S_INTN, 0); ex("rs40_cnt", S_IRQ, 0); ex("line", S_LINE, 2);
    run_line(1'b1, 14, -1, -1);
    ex("ack_int_n", S_INTN, 1); ex("ack_cnt", S_IRQ, 1);
    run_line(1'b1, 14, 30, -1);
    run_to(309, 1'b1);
    ex("vs30_fall_lines", S_VS_FALL, 26); ex("vs30_vso", S_VSO, 0);
    ex("line", S_LINE, 30); ex("irq", S_IRQ, 28);
    run_line(1'b1, 14, -1, -1);

    run_to(332, 1'b0);
    ex("pre_irq", S_IRQ, 51);
    run_line(1'b0, 14, -1, -1);
    ex("irq_int_n", S_INTN, 0); ex("irq_cnt", S_IRQ, 0);
    run_line(1'b0, 14, -1, -1);
    ex("ack_int_n", S_INTN, 1); ex("ack_cnt", S_IRQ, 1);
    run_line(1'b0, 14, 30, -1);
    run_to(353, 1'b0);
    ex("pre_rs20_cnt", S_IRQ, 20);
    run_line(1'b0, 14, -1, -1);
    ex("rs20_le1_cnt", S_IRQ, 21);
    run_line(1'b1, 14, -1, -1);
    ex("rs20_cnt", S_IRQ, 0); ex("rs20_int_n", S_INTN, 1);
    run_line(1'b1, 14, -1, -1);
    run_to(361, 1'b1);
    ex("vs8_vso_high", S_VSO, 1); ex("line", S_LINE, 8);
    run_line(1'b1, 14, -1, -1);
    ex("vs8_fall_with_input", S_VS_T0, 0); ex("vs8_vso", S_VSO, 0);
    ex("line", S_LINE, 9); ex("irq", S_IRQ, 7);
    run_line(1'b0, 14, -1, -1);

`ifdef GA_PRI_EN
    pri_line = 9'd100;
    run_to(406, 1'b0);
    ex("pri_cnt_runs", S_IRQ, 51);
    run_line(1'b0, 14, -1, -1);
    ex("pri_no_periodic", S_INTN, 1); ex("pri_cnt_wrap", S_IRQ, 0);
    run_line(1'b0, 14, -1, -1);
    run_to(452, 1'b0);
    ex("pri_before", S_INTN, 1); ex("line", S_LINE, 99);
    run_line(1'b0, 14, -1, -1);
    ex("pri_hit_int_n", S_INTN, 0); ex("line", S_LINE, 100); ex("pri_hit_cnt", S_IRQ, 46);
    run_line(1'b0, 14, -1, -1);
    ex("pri_ack_int_n", S_INTN, 1); ex("pri_ack_cnt", S_IRQ, 15);
    run_line(1'b0, 14, 30, -1);
    pri_line = 9'd0;
    run_to(490, 1'b0);
    ex("pri_off_pre", S_IRQ, 51); ex("pri_off_pre_int_n", S_INTN, 1);
    run_line(1'b0, 14, -1, -1);
    ex("pri_off_irq_int_n", S_INTN, 0); ex("pri_off_irq_cnt", S_IRQ, 0);
    run_line(1'b0, 14, -1, -1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
